// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: formats byte lanes, runs a req/ack bus access with a timeout and stalls the pipeline meanwhile.
// Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned H/HU/W accesses instead of truncating the address.
module lsu_mem_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd_m,
    input  logic        mem_wr_m,
    input  logic [2:0]  func3_m,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    output logic [31:0] load_data,
    output logic        stall_m,
    output logic        bus_err,
    output logic        misalign,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [2:0]  func3_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic [15:0] cnt_q;
    logic [31:0] load_q;
    logic        err_q;
    logic        mis_q;

    logic        access;
    logic        mis_now;
    logic        timeout_hit;
    logic [3:0]  be_lanes;
    logic [31:0] wd_lanes;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_fmt;

    assign access      = mem_rd_m | mem_wr_m;
    assign timeout_hit = (cnt_q == 16'(TIMEOUT - 1));

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_now = ((func3_m[1:0] == 2'b01) && addr_m[0]) ||
                     ((func3_m[1:0] == 2'b10) && (addr_m[1:0] != 2'b00));
`else
    assign mis_now = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; an ack outside BUSY never moves the FSM
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (access) begin
                    state_nxt = mis_now ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus_ack || timeout_hit) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latched access, timeout counter and DONE-cycle result flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            func3_q <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            load_q  <= '0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            mis_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (access) begin
                        addr_q  <= addr_m;
                        func3_q <= func3_m;
                        wdata_q <= wdata_m;
                        we_q    <= mem_wr_m;
                        cnt_q   <= '0;
                        if (mis_now) begin
                            load_q <= '0;
                            mis_q  <= 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    cnt_q <= cnt_q + 16'd1;
                    if (bus_ack) begin
                        load_q <= we_q ? 32'd0 : rd_fmt;
                    end else if (timeout_hit) begin
                        load_q <= '0;
                        err_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte-lane formatting of the latched access
    always_comb begin
        be_lanes = 4'b1111;
        wd_lanes = wdata_q;
        case (func3_q[1:0])
            2'b00: begin
                be_lanes = 4'b0001 << addr_q[1:0];
                wd_lanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be_lanes = addr_q[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{wdata_q[15:0]}};
            end
            default: ;
        endcase
    end

    // Load extraction: pick the addressed byte/half, then extend by func3
    always_comb begin
        case (addr_q[1:0])
            2'b00:   rd_byte = bus_rdata[7:0];
            2'b01:   rd_byte = bus_rdata[15:8];
            2'b10:   rd_byte = bus_rdata[23:16];
            default: rd_byte = bus_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (func3_q)
            3'b000:  rd_fmt = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  rd_fmt = {{16{rd_half[15]}}, rd_half};
            3'b100:  rd_fmt = {24'd0, rd_byte};
            3'b101:  rd_fmt = {16'd0, rd_half};
            default: rd_fmt = bus_rdata;
        endcase
    end

    // Outputs. Handshake: bus_req stays high from the first BUSY cycle until the
    // cycle bus_ack is seen (or the timeout fires); bus_ack is a one-cycle strobe.
    always_comb begin
        stall_m   = 1'b0;
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_be    = '0;
        bus_wdata = '0;
        case (state)
            S_IDLE: stall_m = access & ~rst;
            S_BUSY: begin
                stall_m   = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = {addr_q[31:2], 2'b00};
                bus_be    = be_lanes;
                bus_wdata = wd_lanes;
            end
            default: ;
        endcase
    end

    assign load_data = load_q;
    assign bus_err   = err_q;
    assign misalign  = mis_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed cases plus random accesses checked cycle by cycle against a transaction model.
module tb_lsu_mem_ctrl;

  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic        mem_rd_m;
  logic        mem_wr_m;
  logic [2:0]  func3_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic [31:0] load_data;
  logic        stall_m;
  logic        bus_err;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic [1:0]  state_dbg;

  lsu_mem_ctrl #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_rd_m  (mem_rd_m),
    .mem_wr_m  (mem_wr_m),
    .func3_m   (func3_m),
    .addr_m    (addr_m),
    .wdata_m   (wdata_m),
    .load_data (load_data),
    .stall_m   (stall_m),
    .bus_err   (bus_err),
    .misalign  (misalign),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic        chk_en = 1'b0;
  logic        exp_stall, exp_req, exp_we, exp_err, exp_mis, exp_ld_chk;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_be;
  logic [31:0] exp_q[$];

  int stall_cnt = 0;
  int req_cnt   = 0;
  int err_cnt   = 0;
  int mis_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // model
  function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 4'(1 << int'(a[1:0]));
      2'b01:   return 4'(3 << (2 * int'(a[1])));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   return {4{wd[7:0]}};
      2'b01:   return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [7:0]  by;
    logic [15:0] hw;
    by = 8'(rd >> (8 * int'(a[1:0])));
    hw = 16'(rd >> (16 * int'(a[1])));
    case (f3)
      3'b000:  return 32'($signed(by));
      3'b001:  return 32'($signed(hw));
      3'b100:  return {24'd0, by};
      3'b101:  return {16'd0, hw};
      default: return rd;
    endcase
  endfunction

  function automatic logic model_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  task automatic set_exp_quiet();
    exp_stall  = 1'b0;
    exp_req    = 1'b0;
    exp_we     = 1'b0;
    exp_err    = 1'b0;
    exp_mis    = 1'b0;
    exp_ld_chk = 1'b0;
    exp_addr   = '0;
    exp_wdata  = '0;
    exp_be     = '0;
    exp_ld     = '0;
  endtask

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (stall_m === 1'b1) stall_cnt++;
    if (bus_req === 1'b1) req_cnt++;
    if (bus_err === 1'b1) err_cnt++;
    if (misalign === 1'b1) mis_cnt++;
    if (chk_en) begin
      check("stall_m", 32'(stall_m), 32'(exp_stall));
      check("bus_req", 32'(bus_req), 32'(exp_req));
      check("bus_err", 32'(bus_err), 32'(exp_err));
      check("misalign", 32'(misalign), 32'(exp_mis));
      if (exp_req) begin
        check("bus_we", 32'(bus_we), 32'(exp_we));
        check("bus_addr", bus_addr, exp_addr);
        check("bus_be", 32'(bus_be), 32'(exp_be));
        check("bus_wdata", bus_wdata, exp_wdata);
      end
      if (exp_ld_chk) begin
        check("load_data", load_data, exp_q.pop_front());
      end
    end
  end

  // driver: one access; ack_at = BUSY cycle (1-based) that carries the ack, 0 = never
  task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int ack_at, input logic [31:0] rdata);
    logic mis;
    logic tmo;
    int   busy_n;
    mis = model_misaligned(f3, a);
    tmo = 1'b0;
    @(posedge clk); #1;
    mem_rd_m  = rd;
    mem_wr_m  = wr;
    func3_m   = f3;
    addr_m    = a;
    wdata_m   = wd;
    bus_ack   = 1'($urandom_range(0, 1));
    bus_rdata = $urandom();
    set_exp_quiet();
    exp_stall = 1'b1;
    chk_en    = 1'b1;
    if (!mis) begin
      tmo    = (ack_at == 0) || (ack_at > TMO);
      busy_n = tmo ? TMO : ack_at;
      for (int i = 1; i <= busy_n; i++) begin
        @(posedge clk); #1;
        bus_ack   = (i == ack_at);
        bus_rdata = (i == ack_at) ? rdata : $urandom();
        exp_req   = 1'b1;
        exp_stall = 1'b1;
        exp_we    = wr;
        exp_addr  = {a[31:2], 2'b00};
        exp_be    = model_be(f3, a);
        exp_wdata = model_wdata(f3, wd);
      end
    end
    // DONE: still-present access and any ack are ignored
    @(posedge clk); #1;
    bus_ack    = 1'($urandom_range(0, 1));
    bus_rdata  = $urandom();
    set_exp_quiet();
    exp_err    = tmo;
    exp_mis    = mis;
    exp_ld_chk = 1'b1;
    exp_q.push_back((tmo || wr || mis) ? 32'd0 : model_load(f3, a, rdata));
    // pipeline advances, access drops
    @(posedge clk); #1;
    mem_rd_m = 1'b0;
    mem_wr_m = 1'b0;
    bus_ack  = 1'($urandom_range(0, 1));
    set_exp_quiet();
  endtask

  task automatic clear_counts();
    stall_cnt = 0;
    req_cnt   = 0;
    err_cnt   = 0;
    mis_cnt   = 0;
  endtask

  task automatic reset_in_busy();
    @(posedge clk); #1;
    mem_rd_m = 1'b1; mem_wr_m = 1'b0; func3_m = 3'b010;
    addr_m = 32'h40; wdata_m = 32'h0; bus_ack = 1'b0;
    set_exp_quiet();
    exp_stall = 1'b1;
    chk_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      exp_req   = 1'b1;
      exp_we    = 1'b0;
      exp_addr  = 32'h40;
      exp_be    = 4'hF;
      exp_wdata = 32'h0;
    end
    @(negedge clk); #1;
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async_req", 32'(bus_req), 32'd0);
    check("rst_async_stall", 32'(stall_m), 32'd0);
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack  = 1'b0;
    mem_rd_m = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    bus_ack = 1'b1;
    set_exp_quiet();
    chk_en = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    mem_rd_m = 1'b0; mem_wr_m = 1'b0; func3_m = 3'b000;
    addr_m = '0; wdata_m = '0; bus_ack = 1'b0; bus_rdata = '0;
    set_exp_quiet();
    #12;
    check("reset_stall", 32'(stall_m), 32'd0);
    check("reset_req", 32'(bus_req), 32'd0);
    check("reset_err", 32'(bus_err), 32'd0);
    check("reset_misalign", 32'(misalign), 32'd0);
    check("reset_load_data", load_data, 32'd0);
    #11 rst = 1'b0;

    // pin the model against hand-computed values
    check("pin_lb", model_load(3'b000, 32'h103, 32'h80112233), 32'hFFFFFF80);
    check("pin_lbu", model_load(3'b100, 32'h103, 32'h80112233), 32'h00000080);
    check("pin_sh_be", 32'(model_be(3'b001, 32'h102)), 32'h0000000C);
    check("pin_sh_wdata", model_wdata(3'b001, 32'h0000ABCD), 32'hABCDABCD);
    check("pin_sw_be", 32'(model_be(3'b010, 32'h100)), 32'h0000000F);

    clear_counts();
    run_txn(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 32'h0);
    check("sw_stall_cycles", 32'(stall_cnt), 32'd2);

    run_txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 1, 32'h80112233);
    run_txn(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);

    clear_counts();
    run_txn(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 5, 32'h0);
    check("sh_stall_cycles", 32'(stall_cnt), 32'd6);

    clear_counts();
    run_txn(1'b1, 1'b0, 3'b010, 32'h200, 32'h0, 0, 32'h0);
    check("timeout_busy_cycles", 32'(req_cnt), 32'(TMO));
    check("timeout_err_pulses", 32'(err_cnt), 32'd1);

    clear_counts();
    run_txn(1'b1, 1'b0, 3'b101, 32'h206, 32'h0, TMO, 32'h8001F00D);
    check("last_cycle_ack_err", 32'(err_cnt), 32'd0);

    reset_in_busy();

    clear_counts();
    run_txn(1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 1, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_stall_cycles", 32'(stall_cnt), 32'd1);
    check("mis_req_cycles", 32'(req_cnt), 32'd0);
    check("mis_pulses", 32'(mis_cnt), 32'd1);
`else
    check("mis_stall_cycles", 32'(stall_cnt), 32'd2);
    check("mis_req_cycles", 32'(req_cnt), 32'd1);
    check("mis_pulses", 32'(mis_cnt), 32'd0);
`endif

    for (int n = 0; n < 150; n++) begin
      int          kind;
      logic        rd, wr;
      logic [2:0]  f3;
      kind = $urandom_range(0, 3);
      rd = (kind != 1);
      wr = (kind == 1) || (kind == 2);
      if (wr) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      run_txn(rd, wr, f3, $urandom(), $urandom(), $urandom_range(0, TMO + 2), $urandom());
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
